// File: rtl/mips_load_wb.sv
// Load writeback unit: accepts one load at a time, waits for the memory read
// response, then aligns/extends the word and drives the register file write port.
module mips_load_wb (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [1:0]  req_alo,
    input  logic [4:0]  req_rd,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        stall,
    output logic        aerr,
    output logic [4:0]  rd,
    output logic [3:0]  we,
    output logic [31:0] D
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LWL = 3'b010,
        OP_LW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_LWR = 3'b110,
        OP_ILL = 3'b111
    } op_t;

    state_t      state;
    state_t      state_next;
    op_t         op_q;
    op_t         req_op_n;
    logic [1:0]  alo_q;
    logic [4:0]  pend_rd;
    logic        accept;
    logic        misaligned;
    logic [31:0] shr_data;
    logic [31:0] shl_data;
    logic [3:0]  we_next;
    logic [31:0] d_next;

    assign req_ready = (state == S_IDLE) || (state == S_WB);
    assign accept    = req_valid && req_ready;

    assign stall = ((state == S_WAIT) || (state == S_WB)) && (pend_rd != 5'd0) &&
                   ((rs == pend_rd) || (rt == pend_rd));

    always_comb begin
        req_op_n = op_t'(req_op);
        if (req_op_n == OP_ILL) begin
            req_op_n = OP_LW;
        end
        misaligned = 1'b0;
        if ((req_op_n == OP_LH) || (req_op_n == OP_LHU)) begin
            misaligned = req_alo[0];
        end else if (req_op_n == OP_LW) begin
            misaligned = (req_alo != 2'd0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && !misaligned) state_next = S_WAIT;
            S_WAIT:  if (mem_valid) state_next = S_WB;
            S_WB:    state_next = (accept && !misaligned) ? S_WAIT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // LWL shifts left by 3-a bytes; ~alo_q is exactly 3-a for a 2-bit offset.
    always_comb begin
        shr_data = mem_data >> {alo_q, 3'b000};
        shl_data = mem_data << {~alo_q, 3'b000};
        we_next  = 4'b1111;
        d_next   = mem_data;
        case (op_q)
            OP_LB:   d_next = {{24{shr_data[7]}}, shr_data[7:0]};
            OP_LBU:  d_next = {24'd0, shr_data[7:0]};
            OP_LH:   d_next = {{16{shr_data[15]}}, shr_data[15:0]};
            OP_LHU:  d_next = {16'd0, shr_data[15:0]};
            OP_LWL: begin
                d_next  = shl_data;
                we_next = 4'b1111 << ~alo_q;
            end
            OP_LWR: begin
                d_next  = shr_data;
                we_next = 4'b1111 >> alo_q;
            end
            default: d_next = mem_data;
        endcase
        if (pend_rd == 5'd0) begin
            we_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= OP_LW;
            alo_q   <= '0;
            pend_rd <= '0;
            rd      <= '0;
            we      <= '0;
            D       <= '0;
            aerr    <= 1'b0;
        end else begin
            state <= state_next;
            aerr  <= accept && misaligned;
            we    <= '0;
            if (accept) begin
                op_q    <= req_op_n;
                alo_q   <= req_alo;
                pend_rd <= req_rd;
            end
            if ((state == S_WAIT) && mem_valid) begin
                rd <= pend_rd;
                we <= we_next;
                D  <= d_next;
            end
        end
    end

endmodule

// File: tb/tb_mips_load_wb.sv
// Self-checking bench for mips_load_wb: directed scenarios plus randomized loads
// compared against a byte-level reference model.
module tb_mips_load_wb;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [1:0]  req_alo;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        stall;
    logic        aerr;
    logic [4:0]  rd;
    logic [3:0]  we;
    logic [31:0] D;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mips_load_wb dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_alo(req_alo), .req_rd(req_rd), .mem_valid(mem_valid),
        .mem_data(mem_data), .rs(rs), .rt(rt), .stall(stall), .aerr(aerr),
        .rd(rd), .we(we), .D(D)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [4:0] r);
        req_valid = 1'b1;
        req_op    = op;
        req_alo   = a;
        req_rd    = r;
        step();
        req_valid = 1'b0;
    endtask

    // Ends sampled just after the edge that enters WB.
    task automatic respond(input logic [31:0] w, input int delay,
                           output int stall_wait, output logic stall_wb);
        stall_wait = 0;
        mem_valid  = 1'b0;
        for (int i = 0; i < delay; i++) begin
            if (stall) stall_wait++;
            step();
        end
        if (stall) stall_wait++;
        mem_valid = 1'b1;
        mem_data  = w;
        step();
        mem_valid = 1'b0;
        mem_data  = $urandom;
        stall_wb  = stall;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] en);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 4; j++) if (en[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference: memory bytes b[0..3] (little endian) mapped into register lanes.
    function automatic void model(input logic [2:0] op_in, input logic [1:0] a,
                                  input logic [31:0] w, input logic [4:0] r,
                                  output logic [3:0] ewe, output logic [31:0] ed,
                                  output bit mis);
        int     b[4];
        int     ai;
        int     op;
        longint v;
        ai = int'(a);
        op = int'(op_in);
        for (int i = 0; i < 4; i++) b[i] = int'((w >> (8 * i)) & 32'hFF);
        if (op == 7) op = 3;
        ewe = 4'b1111;
        ed  = '0;
        mis = 1'b0;
        case (op)
            0, 4: begin
                v = b[ai];
                if (op == 0 && v >= 128) v -= 256;
                ed = 32'(v);
            end
            1, 5: begin
                if (ai % 2 != 0) mis = 1'b1;
                else begin
                    v = b[ai] + 256 * b[ai + 1];
                    if (op == 1 && v >= 32768) v -= 65536;
                    ed = 32'(v);
                end
            end
            3: begin
                if (ai != 0) mis = 1'b1;
                else ed = w;
            end
            2: begin
                ewe = '0;
                for (int j = 0; j < 4; j++) if (j >= 3 - ai) begin
                    ewe[j] = 1'b1;
                    ed[8*j +: 8] = 8'(b[j - (3 - ai)]);
                end
            end
            default: begin
                ewe = '0;
                for (int j = 0; j < 4; j++) if (j + ai <= 3) begin
                    ewe[j] = 1'b1;
                    ed[8*j +: 8] = 8'(b[j + ai]);
                end
            end
        endcase
        if (mis || r == 5'd0) ewe = '0;
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_alo = '0; req_rd = '0;
        mem_valid = 1'b0; mem_data = '0; rs = '0; rt = '0;
        step(); step();
        reset = 1'b0;
        n_checks++;
        if (we !== 4'b0000 || rd !== 5'd0 || D !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b rd=%0d D=%h, expected 0000/0/0", we, rd, D);
        end
        n_checks++;
        if (aerr !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: got aerr=%b stall=%b ready=%b, expected 0/0/1", aerr, stall, req_ready);
        end
    endtask

    task automatic test_spec_examples();
        logic [2:0]  ops [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110};
        logic [1:0]  alos[6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        logic [31:0] ws  [6] = '{32'h12803456, 32'h12803456, 32'h80011234, 32'h80011234,
                                 32'hAABBCCDD, 32'hAABBCCDD};
        logic [3:0]  ewe [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b0111};
        logic [31:0] ed  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                 32'hCCDD0000, 32'h00AABBCC};
        int   sw;
        logic sb;
        rs = 5'd20; rt = 5'd21;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], alos[i], 5'd5);
            respond(ws[i], 1, sw, sb);
            n_checks++;
            if (we !== ewe[i] || rd !== 5'd5 ||
                (D & lane_mask(ewe[i])) !== (ed[i] & lane_mask(ewe[i]))) begin
                n_fail++;
                $display("FAIL example_%0d: got we=%b rd=%0d D=%h, expected we=%b rd=5 D=%h",
                         i, we, rd, D, ewe[i], ed[i]);
            end
            step();
            n_checks++;
            if (we !== 4'b0000 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL example_%0d_after_wb: got we=%b ready=%b, expected 0000/1", i, we, req_ready);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [2:0] ops [3] = '{3'b001, 3'b101, 3'b011};
        logic [1:0] alos[3] = '{2'd1, 2'd3, 2'd2};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], alos[i], 5'd6);
            n_checks++;
            if (aerr !== 1'b1 || we !== 4'b0000 || req_ready !== 1'b1 || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL misaligned_%0d: got aerr=%b we=%b ready=%b stall=%b, expected 1/0000/1/0",
                         i, aerr, we, req_ready, stall);
            end
            mem_valid = 1'b1;
            step();
            mem_valid = 1'b0;
            n_checks++;
            if (aerr !== 1'b0 || we !== 4'b0000) begin
                n_fail++;
                $display("FAIL misaligned_pulse_%0d: got aerr=%b we=%b, expected 0/0000", i, aerr, we);
            end
        end
    endtask

    task automatic test_stall();
        int   sw;
        logic sb;
        rs = 5'd7; rt = 5'd1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle: got %b expected 0", stall);
        end
        issue(3'b011, 2'd0, 5'd7);
        respond(32'h01020304, 3, sw, sb);
        n_checks++;
        if (sw !== 4 || sb !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hazard: got wait_cycles_stalled=%0d wb_stall=%b, expected 4/1", sw, sb);
        end
        step();
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got %b expected 0", stall);
        end
        rs = 5'd2; rt = 5'd7;
        issue(3'b000, 2'd0, 5'd7);
        respond(32'h000000FF, 0, sw, sb);
        n_checks++;
        if (sw !== 1 || sb !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_rt: got wait_cycles_stalled=%0d wb_stall=%b, expected 1/1", sw, sb);
        end
        step();
    endtask

    task automatic test_rd_zero();
        int   sw;
        logic sb;
        rs = 5'd0; rt = 5'd0;
        issue(3'b011, 2'd0, 5'd0);
        respond(32'hDEADBEEF, 1, sw, sb);
        n_checks++;
        if (we !== 4'b0000 || sw !== 0 || sb !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_zero: got we=%b wait_stall=%0d wb_stall=%b, expected 0000/0/0", we, sw, sb);
        end
        step();
    endtask

    task automatic test_illegal_op();
        int   sw;
        logic sb;
        rs = 5'd0; rt = 5'd0;
        issue(3'b111, 2'd0, 5'd12);
        respond(32'hCAFEF00D, 0, sw, sb);
        n_checks++;
        if (we !== 4'b1111 || D !== 32'hCAFEF00D || rd !== 5'd12) begin
            n_fail++;
            $display("FAIL illegal_as_lw: got we=%b D=%h rd=%0d, expected 1111/cafef00d/12", we, D, rd);
        end
        step();
        issue(3'b111, 2'd1, 5'd12);
        n_checks++;
        if (aerr !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_misaligned: got aerr=%b expected 1", aerr);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int   sw;
        logic sb;
        rs = 5'd0; rt = 5'd0;
        issue(3'b000, 2'd0, 5'd3);
        respond(32'h0000007F, 0, sw, sb);
        n_checks++;
        if (we !== 4'b1111 || D !== 32'h0000007F || rd !== 5'd3 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got we=%b D=%h rd=%0d ready=%b, expected 1111/0000007f/3/1",
                     we, D, rd, req_ready);
        end
        issue(3'b101, 2'd2, 5'd4);
        n_checks++;
        if (req_ready !== 1'b0 || we !== 4'b0000 || aerr !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_enter_wait: got ready=%b we=%b aerr=%b, expected 0/0000/0", req_ready, we, aerr);
        end
        respond(32'hFFEE1234, 2, sw, sb);
        n_checks++;
        if (we !== 4'b1111 || D !== 32'h0000FFEE || rd !== 5'd4) begin
            n_fail++;
            $display("FAIL b2b_second: got we=%b D=%h rd=%0d, expected 1111/0000ffee/4", we, D, rd);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        int   sw;
        logic sb;
        rs = 5'd9; rt = 5'd0;
        issue(3'b011, 2'd0, 5'd9);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_pre: got stall=%b expected 1", stall);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (we !== 4'b0000 || rd !== 5'd0 || D !== 32'd0 || aerr !== 1'b0 ||
            stall !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_wait: got we=%b rd=%0d D=%h aerr=%b stall=%b ready=%b, expected 0/0/0/0/0/1",
                     we, rd, D, aerr, stall, req_ready);
        end
        mem_valid = 1'b1;
        mem_data  = 32'h11223344;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (we !== 4'b0000 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stale_mem_valid_%0d: got we=%b ready=%b, expected 0000/1", i, we, req_ready);
            end
        end
        mem_valid = 1'b0;
        issue(3'b011, 2'd0, 5'd9);
        respond(32'h55667788, 0, sw, sb);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (we !== 4'b0000 || D !== 32'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_wb: got we=%b D=%h stall=%b, expected 0000/0/0", we, D, stall);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [1:0]  a;
        logic [4:0]  r;
        logic [31:0] w;
        logic [3:0]  ewe;
        logic [31:0] ed;
        bit          mis;
        int          dly;
        int          sw;
        logic        sb;
        logic        exp_stall;
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = 2'($urandom_range(0, 3));
            r   = 5'($urandom_range(0, 31));
            w   = $urandom;
            dly = $urandom_range(0, 3);
            rs  = ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31));
            rt  = 5'($urandom_range(0, 31));
            model(op, a, w, r, ewe, ed, mis);
            exp_stall = (r != 5'd0) && (rs == r || rt == r);
            issue(op, a, r);
            n_checks++;
            if (aerr !== mis) begin
                n_fail++;
                $display("FAIL rand_%0d_aerr: op=%0d a=%0d got aerr=%b expected %b", n, op, a, aerr, mis);
            end
            if (!mis) begin
                respond(w, dly, sw, sb);
                n_checks++;
                if (we !== ewe || (ewe != 4'b0000 && rd !== r) ||
                    (D & lane_mask(ewe)) !== (ed & lane_mask(ewe))) begin
                    n_fail++;
                    $display("FAIL rand_%0d_wb: op=%0d a=%0d w=%h r=%0d got we=%b rd=%0d D=%h expected we=%b D=%h",
                             n, op, a, w, r, we, rd, D, ewe, ed);
                end
                n_checks++;
                if (sb !== exp_stall || sw !== (exp_stall ? dly + 1 : 0)) begin
                    n_fail++;
                    $display("FAIL rand_%0d_stall: got wait=%0d wb=%b expected wait=%0d wb=%b",
                             n, sw, sb, exp_stall ? dly + 1 : 0, exp_stall);
                end
            end
            step();
            n_checks++;
            if (we !== 4'b0000 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_%0d_idle: got we=%b ready=%b expected 0000/1", n, we, req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_examples();
        test_misaligned();
        test_stall();
        test_rd_zero();
        test_illegal_op();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
